// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, register index, stage-register FSM states and
// the packed payloads carried between pipeline stages.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_t;

  typedef struct packed {
    word_t instr;
    word_t pcNext;
  } ifid_t;

  typedef struct packed {
    word_t    rdat1;
    word_t    rdat2;
    word_t    imm;
    word_t    pcNext;
    regbits_t rd;
    logic     regWen;
    logic     memRen;
    logic     memWen;
  } idex_t;

  typedef struct packed {
    word_t    aluOut;
    word_t    storeData;
    regbits_t rd;
    logic     regWen;
    logic     memRen;
    logic     memWen;
  } exmem_t;

  typedef struct packed {
    word_t    result;
    regbits_t rd;
    logic     regWen;
  } memwb_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, optional two-entry
// skid buffer (registered in_ready), synchronous flush and saturating stall counter.
module pipe_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             inFire;
  logic             outFire;
  logic [CNT_W-1:0] stallCnt;

  assign inFire  = in_valid & in_ready;
  assign outFire = out_valid & out_ready;

  generate
    if (SKID != 0) begin : gSkid
      pipe_state_t       state, stateNext;
      logic [DATA_W-1:0] mainD, mainDNext, skidD, skidDNext;
      logic              mainV, skidV;

      always_comb begin
        stateNext = state;
        mainDNext = mainD;
        skidDNext = skidD;
        unique case (state)
          EMPTY: begin
            if (inFire) begin
              mainDNext = in_data;
              stateNext = ONE;
            end
          end
          ONE: begin
            if (inFire && outFire) begin
              mainDNext = in_data;
            end else if (outFire) begin
              stateNext = EMPTY;
            end else if (inFire) begin
              skidDNext = in_data;
              stateNext = FULL;
            end
          end
          FULL: begin
            if (outFire) begin
              mainDNext = skidD;
              stateNext = ONE;
            end
          end
          default: stateNext = EMPTY;
        endcase
        // Flush leaves zero payloads behind so a bubble is always all-zero.
        if (flush) begin
          stateNext = EMPTY;
          mainDNext = '0;
          skidDNext = '0;
        end
      end

      // Valid bits are registered copies of the next state so in_ready comes straight off a flop.
      always_ff @(posedge CLK) begin
        if (RST) begin
          state <= EMPTY;
          mainD <= '0;
          skidD <= '0;
          mainV <= 1'b0;
          skidV <= 1'b0;
        end else begin
          state <= stateNext;
          mainD <= mainDNext;
          skidD <= skidDNext;
          mainV <= (stateNext != EMPTY);
          skidV <= (stateNext == FULL);
        end
      end

      assign in_ready  = ~skidV;
      assign out_valid = mainV;
      assign out_data  = mainD;
      assign occupancy = {skidV, mainV & ~skidV};
    end else begin : gSingle
      logic              mainV;
      logic [DATA_W-1:0] mainD;

      always_ff @(posedge CLK) begin
        if (RST) begin
          mainV <= 1'b0;
          mainD <= '0;
        end else if (flush) begin
          mainV <= 1'b0;
          mainD <= '0;
        end else if (inFire) begin
          mainV <= 1'b1;
          mainD <= in_data;
        end else if (outFire) begin
          mainV <= 1'b0;
        end
      end

      assign in_ready  = ~mainV | out_ready;
      assign out_valid = mainV;
      assign out_data  = mainD;
      assign occupancy = {1'b0, mainV};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      stallCnt <= '0;
    end else if (in_valid && !in_ready && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign stall_cnt = stallCnt;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, an optional two-entry skid buffer, synchronous flush and a saturating stall counter. It is the generic successor to the per-stage latch interfaces: IF/ID, ID/EX, EX/MEM and MEM/WB each instantiate one with a packed stage-payload struct. Upstream sees a registered `in_ready` when `SKID=1`. The hazard unit drives `flush` and backpressure through `out_ready`.

## Interface
- `DATA_W`, default 32: width of the packed payload. Instantiate with `$bits(<stage>_t)`.
- `SKID`, default 1: 1 selects the two-entry skid buffer with registered `in_ready`; 0 selects a single register with combinational `in_ready`.
- `CNT_W`, default 16: width of the stall counter.
- `CLK` in 1: the single clock. All state updates on its rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `in_valid` in 1: upstream payload is valid.
- `in_ready` out 1: this stage accepts the payload this cycle.
- `in_data` in `DATA_W`: upstream payload.
- `out_valid` out 1: payload held for downstream.
- `out_ready` in 1: downstream accepts. 0 means stall.
- `out_data` out `DATA_W`: registered payload.
- `flush` in 1: discard all held entries at the next edge.
- `occupancy` out 2: number of entries held (0..2).
- `stall_cnt` out `CNT_W`: cycles in which `in_valid & !in_ready`.

## Operation
- A transfer (fire) occurs on a side when its valid and ready are both 1 at the rising edge: `in_fire = in_valid & in_ready`, `out_fire = out_valid & out_ready`.
- Storage:
  - main register (`main_v`, `main_d`) drives `out_valid` and `out_data`.
  - skid register (`skid_v`, `skid_d`) exists only when `SKID=1`.
- State `pipe_state_t` for `SKID=1`: EMPTY (occupancy 0), ONE (1), FULL (2).
  - EMPTY: on `in_fire`, main ← `in_data` and go to ONE. Otherwise stay.
  - ONE, `in_fire & out_fire`: main ← `in_data`, stay in ONE.
  - ONE, `out_fire` only: go to EMPTY.
  - ONE, `in_fire` only: skid ← `in_data`, go to FULL.
  - ONE, neither: hold.
  - FULL: `in_ready = 0`. On `out_fire`, main ← skid and go to ONE. Otherwise hold.
  - `in_ready = !skid_v`, driven directly from a flop.
- `SKID=0`:
  - `in_ready = !main_v | out_ready`, combinational.
  - On `in_fire`, main ← `in_data`.
  - On `out_fire` without `in_fire`, `main_v` ← 0.
  - `occupancy` is 0 or 1.
- Payload ordering: strictly FIFO. The skid entry is never presented before the main entry.
- Priority at the edge: `RST` > `flush` > normal operation.
- `flush`:
  - next state is EMPTY.
  - `main_d` and `skid_d` are cleared to 0, so a bubble is a zero payload.
  - A payload that fires on `in_fire` in the flush cycle is dropped.
  - `stall_cnt` is not affected.
- `stall_cnt`:
  - increments by 1 in each cycle with `in_valid & !in_ready`, including flush cycles.
  - saturates at 2^`CNT_W`−1 and does not wrap.
  - is cleared only by `RST`.
- The block never modifies `out_data` while `out_valid & !out_ready`. The payload is stable under stall.

## Timing
- Reset values, present in the cycle after `RST` is sampled high:
  - `out_valid` = 0, `out_data` = 0, `occupancy` = 0, `stall_cnt` = 0.
  - `in_ready` = 1 in both modes.
- Reset applied mid-operation discards all entries, exactly as for flush, and also clears the counter.
- Latency: a payload accepted at edge N is on `out_data` with `out_valid` = 1 after edge N; it is visible in cycle N+1.
- Throughput: one transfer per cycle while `out_ready` = 1.
- Backpressure reaches `in_ready` when `SKID=1`:
  - one cycle after the skid entry fills;
  - it recovers to 1 the cycle after the `out_fire` that drains FULL.
- Simultaneous `in_fire` and `out_fire` in ONE keeps occupancy unchanged; there is no bubble.
- Maximum occupancy is 2. In FULL there is no overflow path, because `in_ready` = 0.

## Structure
- `cpu_types_pkg` gets:
  - `typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_t`;
  - the packed stage payload structs (`ifid_t`, `idex_t`, `exmem_t`, `memwb_t`), built from the existing `word_t` and `regbits_t`.
- The datapath instantiates `pipe_stage_reg #(.DATA_W($bits(exmem_t)))` and casts the payload to and from the struct.
- Single module with no sub-module. The skid slot is too small to justify splitting out. The `SKID` selection is a generate branch.

## Test plan
- Reset: hold `RST` for 2 cycles with `in_valid` = 1 and `in_data` = 0xDEADBEEF -> `out_valid` = 0, `out_data` = 0, `occupancy` = 0, `in_ready` = 1, `stall_cnt` = 0.
- Streaming: present 0x1, 0x2, 0x3 on consecutive cycles with `out_ready` = 1 -> `out_data` shows 0x1, 0x2, 0x3 in cycles 1–3, `occupancy` stays 1, no bubble.
- Stall fill/drain (`SKID=1`): send 0xA, 0xB, 0xC with `out_ready` = 0 -> after edge 2 `occupancy` = 2 and `in_ready` = 0, 0xC is held off, `stall_cnt` increments each waiting cycle. Raise `out_ready` -> output order is 0xA, 0xB, 0xC and `out_data` is stable during the stall.
- Flush: `flush` = 1 in FULL while `in_valid` = 1 with 0x55 -> next cycle `out_valid` = 0, `occupancy` = 0, 0x55 never appears, `stall_cnt` unchanged except for a stall in that cycle.
- Saturation: with `CNT_W` = 4, hold a stall for 20 cycles -> `stall_cnt` stops at 15 with no wrap.
- `SKID=0`: with `out_valid` = 1 and `out_ready` = 0 -> `in_ready` = 0 in the same cycle. Setting `out_ready` = 1 with `in_valid` = 1 -> new data is loaded in the same cycle, and `occupancy` never exceeds 1.
